systolic_skew_feeder: RTL

//   Upstream feeder for the SYSTOLIC tile. Accepts one k-slice per handshake:
//   A column k on A_COL, B row k on B_ROW. Emits them as the diagonally skewed

---
 rtl/systolic_pkg.sv | 12 +
 rtl/systolic_skew_feeder_if.sv | 13 +
 rtl/skew_delay_line.sv | 20 ++
 rtl/systolic_skew_feeder.sv | 98 +++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, feeder state encoding and lane slicing helper
//   DEF_DATA_W / DEF_TILE_SIZE : default element width and tile edge
//   feeder_state_t             : IDLE, STREAM, FLUSH, DONE_S
//   lane_lo()                  : low bit index of a lane in a packed lane bus
package systolic_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TILE_SIZE = 2;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE_S} feeder_state_t;
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction
endpackage

// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: slice input handshake into the skew feeder
//   in_valid : slice on a_col/b_row is valid (master -> slave)
//   in_ready : feeder accepts a slice this cycle (slave -> master)
//   a_col    : lane i = A[i][k], lane 0 in LSBs
//   b_row    : lane j = B[k][j], lane 0 in LSBs
interface systolic_skew_feeder_if #(parameter int TILE_SIZE = 2, parameter int DATA_W = 32);
  logic in_valid;
  logic in_ready;
  logic [TILE_SIZE*DATA_W-1:0] a_col;
  logic [TILE_SIZE*DATA_W-1:0] b_row;
  modport master(output in_valid, a_col, b_row, input in_ready);
  modport slave(input in_valid, a_col, b_row, output in_ready);
endinterface

// File: rtl/skew_delay_line.sv
// skew_delay_line: enable-gated shift register, DEPTH stages including the output register
//   clk, rst : clock, async active-high reset (clears every stage)
//   en       : shift one stage when high
//   d / q    : head input / tail output
module skew_delay_line #(parameter int DEPTH = 1, parameter int DATA_W = 32) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] sr [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '{default: '0};
    else if (en) begin
      sr[0] <= d;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: accepts k-slices and emits diagonally skewed edge streams for the tile
//   clk, rst     : clock, async active-high reset
//   start, k_len : begin a job of k_len slices (sampled in IDLE only)
//   busy, done   : job in progress / one-cycle end-of-job pulse
//   in_bus       : slice handshake (slave side)
//   out_en       : edge data valid, drives tile EN
//   n_rx, n_cx   : row/column edge lanes, lane i delayed i shifts
//   stall_cnt    : STREAM cycles without a fire (only with FEEDER_STALL_CNT_EN)
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int TILE_SIZE = DEF_TILE_SIZE,
  parameter int DATA_W = DEF_DATA_W,
  parameter int KLEN_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [KLEN_W-1:0]           k_len,
  output logic                        busy,
  systolic_skew_feeder_if.slave       in_bus,
  output logic                        out_en,
  output logic [TILE_SIZE*DATA_W-1:0] n_rx,
  output logic [TILE_SIZE*DATA_W-1:0] n_cx,
`ifdef FEEDER_STALL_CNT_EN
  output logic [15:0]                 stall_cnt,
`endif
  output logic                        done
);
  localparam int FLUSH_LEN = 2*TILE_SIZE-1;
  localparam int FC_W = $clog2(FLUSH_LEN+1);
  feeder_state_t state;
  logic ready, fire, shift;
  logic [KLEN_W-1:0] klen, cnt;
  logic [FC_W-1:0] fc;
  assign in_bus.in_ready = ready;
  assign fire = in_bus.in_valid & ready;
  // stalls freeze every lane together, so the diagonal skew survives any gap pattern
  assign shift = fire | (state == FLUSH);
  for (genvar i = 0; i < TILE_SIZE; i++) begin : g_lane
    skew_delay_line #(.DEPTH(i+1), .DATA_W(DATA_W)) u_row (
      .clk(clk), .rst(rst), .en(shift),
      .d(fire ? in_bus.a_col[lane_lo(i, DATA_W) +: DATA_W] : '0),
      .q(n_rx[lane_lo(i, DATA_W) +: DATA_W])
    );
    skew_delay_line #(.DEPTH(i+1), .DATA_W(DATA_W)) u_col (
      .clk(clk), .rst(rst), .en(shift),
      .d(fire ? in_bus.b_row[lane_lo(i, DATA_W) +: DATA_W] : '0),
      .q(n_cx[lane_lo(i, DATA_W) +: DATA_W])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      ready <= 1'b0;
      out_en <= 1'b0;
      done <= 1'b0;
      klen <= '0;
      cnt <= '0;
      fc <= '0;
    end else begin
      out_en <= shift;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          klen <= k_len;
          cnt <= '0;
          fc <= '0;
          busy <= 1'b1;
          ready <= k_len != '0;
          state <= k_len == '0 ? DONE_S : STREAM;
        end
        STREAM: if (fire) begin
          cnt <= cnt + KLEN_W'(1);
          if (cnt == klen - KLEN_W'(1)) begin
            ready <= 1'b0;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          fc <= fc + FC_W'(1);
          if (fc == FC_W'(FLUSH_LEN-1)) state <= DONE_S;
        end
        DONE_S: begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (state == IDLE && start) stall_cnt <= '0;
    else if (state == STREAM && !fire && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule
